// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD stopwatch controller and its digit counters.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        OVF
    } state_t;

    localparam logic [3:0]  BCD_MAX    = 4'd9;
    localparam int unsigned MAX_DIGITS = 16;

    // The vector is zero-padded to MAX_DIGITS nibbles; only the low 'digits' nibbles are inspected.
    function automatic logic all_nines(input logic [4*MAX_DIGITS-1:0] v, input int unsigned digits);
        logic r;
        r = 1'b1;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits && v[4*i +: 4] != BCD_MAX) begin
                r = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_stopwatch_ctrl_digit.sv
// Single modulo-10 BCD digit counter with synchronous clear and increment enable.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       is_nine
);

    logic [3:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc) begin
            q_d = (q_q == BCD_MAX) ? '0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q       = q_q;
    assign is_nine = (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Start/stop/clear stopwatch sequencer: FSM-gated prescaler feeding a carry chain of BCD digits, with lap capture.
module bcd_stopwatch_ctrl
    import bcd_pkg::*;
#(
    parameter  int unsigned DIGITS   = 4,
    parameter  int unsigned PRESCALE = 10,
    localparam int unsigned PS_W     = $clog2(PRESCALE + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    input  logic                lap,
    output logic [4*DIGITS-1:0] bcd,
    output logic [4*DIGITS-1:0] lap_bcd,
    output logic                lap_valid,
    output logic                tick,
    output logic                running,
    output logic                overflow
);

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    state_t              state_q, state_d;
    logic [PS_W-1:0]     ps_q, ps_d;
    logic [4*DIGITS-1:0] lap_bcd_q, lap_bcd_d;
    logic                lap_valid_q, lap_valid_d;

    logic                ps_hit;
    logic                full;
    logic                cnt_en;
    logic                lap_acc;
    logic [DIGITS-1:0]   nine;
    logic [DIGITS-1:0]   inc;
    logic [4*MAX_DIGITS-1:0] bcd_pad;

    // stop and clear both outrank the tick, so a coincident pulse suppresses it
    assign ps_hit  = (state_q == RUN) && !clear && !stop && (ps_q == PS_LAST);
    assign cnt_en  = ps_hit && !full;
    assign lap_acc = lap && !clear && (state_q != IDLE);

    always_comb begin
        bcd_pad = '0;
        bcd_pad[4*DIGITS-1:0] = bcd;
    end

    assign full = all_nines(bcd_pad, DIGITS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (ps_hit && full) begin
                        state_d = OVF;
                    end
                end
                PAUSE:   if (start) state_d = RUN;
                OVF:     state_d = OVF;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        tick     = ps_hit;
        running  = (state_q == RUN);
        overflow = (state_q == OVF);
    end

    always_comb begin
        ps_d = ps_q;
        if (clear) begin
            ps_d = '0;
        end else if (state_q == RUN && !stop) begin
            ps_d = ps_hit ? '0 : ps_q + PS_W'(1);
        end
    end

    always_comb begin
        lap_bcd_d   = lap_acc ? bcd : lap_bcd_q;
        lap_valid_d = lap_acc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps_q        <= '0;
            lap_bcd_q   <= '0;
            lap_valid_q <= 1'b0;
        end else begin
            ps_q        <= ps_d;
            lap_bcd_q   <= lap_bcd_d;
            lap_valid_q <= lap_valid_d;
        end
    end

    assign lap_bcd   = lap_bcd_q;
    assign lap_valid = lap_valid_q;

    // digit i advances when the gated tick is present and every lower digit reads nine
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        localparam logic [DIGITS-1:0] LOW = {DIGITS{1'b1}} >> (DIGITS - i);

        assign inc[i] = cnt_en && (&(nine | ~LOW));

        bcd_digit u_digit (
            .clk     (clk),
            .reset   (reset),
            .clr     (clear),
            .inc     (inc[i]),
            .q       (bcd[4*i +: 4]),
            .is_nine (nine[i])
        );
    end

endmodule
